// File: rtl/if_stage_pkg.sv
// Shared definitions for the mips_16 instruction-fetch stage: FSM states,
// reset PC, NOP opcode and the branch-offset sign extension.
package if_stage_pkg;

  localparam logic [3:0]  OP_NOP      = 4'h0;
  localparam logic [15:0] IF_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_REDIRECT = 2'd2
  } if_state_e;

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch port: request/ready handshake with a same-cycle
// read-data return.
interface if_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_stage_skid_buffer.sv
// One-entry holding slot for a word (and its PC) that completes while ID is
// stalled. Flush beats load, load beats unload.
module if_skid_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_flush,
  input  logic [15:0] i_data,
  input  logic [15:0] i_pc,
  output logic        o_full,
  output logic [15:0] o_data,
  output logic [15:0] o_pc
);

  logic        r_full;
  logic [15:0] r_data;
  logic [15:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_pc   <= '0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
      r_pc   <= i_pc;
    end else if (i_unload) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;
  assign o_pc   = r_pc;

endmodule

// File: rtl/if_stage.sv
// mips_16 instruction-fetch stage: owns the PC, fetches over a req/ready port,
// and drives the IF/ID register with branch squash, stall hold and wait bubbles.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = IF_RESET_PC,
  parameter logic [15:0] NOP_INSTR = {OP_NOP, 12'b0}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instruction_fetch_en,
  input  logic             branch_taken,
  input  logic [5:0]       branch_offset_imm,
  if_stage_if.master       imem,
  output logic [15:0]      instruction,
  output logic [15:0]      pc_id
);

  if_state_e   r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [15:0] r_instr, w_instr_nxt;
  logic [15:0] r_pc_id, w_pc_id_nxt;
  logic [15:0] r_tgt, w_tgt_nxt;

  logic        w_req, w_xfer, w_target_dummy;
  logic [15:0] w_target;
  logic        w_buf_full, w_buf_load, w_buf_unload, w_buf_flush;
  logic [15:0] w_buf_data, w_buf_pc;

  assign w_target_dummy = 1'b0;
  assign w_target       = r_pc_id + 16'd1 + sext6(branch_offset_imm);
  assign w_xfer         = w_req & imem.imem_ready;

  if_skid_buffer u_skid (
    .clk      (clk),
    .rst_n    (rst),
    .i_load   (w_buf_load),
    .i_unload (w_buf_unload),
    .i_flush  (w_buf_flush),
    .i_data   (imem.imem_rdata),
    .i_pc     (r_pc),
    .o_full   (w_buf_full),
    .o_data   (w_buf_data),
    .o_pc     (w_buf_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_pc_id <= RESET_PC;
      r_tgt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_pc_id <= w_pc_id_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_instr_nxt  = r_instr;
    w_pc_id_nxt  = r_pc_id;
    w_tgt_nxt    = r_tgt;
    w_req        = 1'b0;
    w_buf_load   = 1'b0;
    w_buf_unload = 1'b0;
    w_buf_flush  = 1'b0;

    unique case (r_state)
      ST_IDLE:     w_state_nxt = ST_FETCH;
      ST_FETCH:    w_req = ~w_buf_full;
      ST_REDIRECT: w_req = 1'b1;
      default:     w_state_nxt = ST_IDLE;
    endcase

    if (r_state == ST_REDIRECT) begin
      // The in-flight word belongs to the squashed path: complete it, drop it.
      if (instruction_fetch_en) w_instr_nxt = NOP_INSTR;
      if (w_xfer) begin
        w_pc_nxt    = r_tgt;
        w_state_nxt = ST_FETCH;
      end
    end else if (instruction_fetch_en) begin
      if (branch_taken) begin
        w_instr_nxt = NOP_INSTR;
        w_buf_flush = 1'b1;
        // A pending request must keep its address, so park the target instead.
        if (w_req && !imem.imem_ready) begin
          w_tgt_nxt   = w_target;
          w_state_nxt = ST_REDIRECT;
        end else begin
          w_pc_nxt = w_target;
        end
      end else if (w_buf_full) begin
        w_instr_nxt  = w_buf_data;
        w_pc_id_nxt  = w_buf_pc;
        w_buf_unload = 1'b1;
      end else if (w_xfer) begin
        w_instr_nxt = imem.imem_rdata;
        w_pc_id_nxt = r_pc;
        w_pc_nxt    = r_pc + 16'd1;
      end else begin
        w_instr_nxt = NOP_INSTR;
      end
    end else if (w_xfer) begin
      w_buf_load = 1'b1;
      w_pc_nxt   = r_pc + 16'd1;
    end
  end

  assign imem.imem_req  = w_req | w_target_dummy;
  assign imem.imem_addr = r_pc;
  assign instruction    = r_instr;
  assign pc_id          = r_pc_id;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the mips_16 five-stage pipeline. It sits directly upstream of ID_stage.
- Owns the PC and issues word fetches to instruction memory over a req/ready handshake.
- Drives the IF/ID pipeline register (`instruction`) that ID_stage decodes.
- Redirects on `branch_taken` / `branch_offset_imm` from ID_stage; holds on hazard-unit stall; inserts NOP bubbles on squash or memory wait.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, bubble encoding ({OP_NOP,12'b0}).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instruction_fetch_en  in  1  from hazard unit; 0 = stall IF and the IF/ID register.
- branch_taken  in  1  from ID_stage; the branch currently in ID is taken.
- branch_offset_imm  in  6  from ID_stage; signed word offset.
- imem_req  out  1  fetch request.
- imem_addr  out  16  word address of the request.
- imem_ready  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  16  fetched instruction word.
- instruction  out  16  IF/ID register to ID_stage.
- pc_id  out  16  PC of the word currently in `instruction` (needed for branch target).

Behaviour:
- Reset (asynchronous, rst=0):
  - pc=RESET_PC; instruction=NOP_INSTR; pc_id=RESET_PC; imem_req=0.
  - Buffer empty; state=IDLE; redirect register cleared.
- Transfer: a transfer occurs on a cycle with imem_req=1 and imem_ready=1.
- Address stability: imem_addr and imem_req must stay stable while imem_req=1 and imem_ready=0.
- PC arithmetic:
  - 16-bit word addressing; sequential next PC = pc+1, wrapping 16'hFFFF→16'h0000.
  - Branch target = pc_id + 1 + sign_extend(branch_offset_imm), modulo 2^16.
- States:
  - IDLE: first cycle after reset release; imem_req=0 → FETCH.
  - FETCH: imem_req=1 unless the 1-entry skid buffer is full; imem_addr=pc.
  - REDIRECT: a branch arrived while a request was pending. Keep the old request until ready, discard its data, load pc=target → FETCH.
- Next state from FETCH:
  - branch_taken=1 & instruction_fetch_en=1 & request pending-not-ready → REDIRECT (target latched).
  - Otherwise stay in FETCH.
- IF/ID update, only when instruction_fetch_en=1. Priority:
  1. branch_taken=1: instruction←NOP_INSTR (squash the fall-through word). Any transfer this cycle is discarded. pc←target; buffer cleared.
  2. Buffer full: instruction←buffer, pc_id←buffered PC; buffer empties.
  3. Transfer this cycle: instruction←imem_rdata, pc_id←imem_addr; pc←pc+1.
  4. Else (memory wait): instruction←NOP_INSTR; pc_id unchanged.
- When instruction_fetch_en=0:
  - instruction and pc_id hold.
  - branch_taken is ignored (ID is stalled, so its branch is not yet final).
  - A transfer completing during the stall is captured into the buffer with its PC; pc←pc+1.
  - imem_req drops once the buffer is full.
- Branch latency: target is requested in the cycle after branch_taken (state FETCH). Exactly one NOP enters ID per taken branch, more if memory waits or REDIRECT applies.
- Simultaneous branch_taken and a full buffer: the buffer is flushed and branch wins.
- Reset asserted mid-request: all state is cleared immediately. The pending request is abandoned; imem_req=0 until the cycle after IDLE.

Decomposition:
- Shared mips_16_defs.v gains IF_RESET_PC and reuses OP_NOP to form NOP_INSTR.
- One natural sub-module: if_skid_buffer (1-entry: data + PC + full flag, load/unload/flush).
- PC/target adder and the FSM stay in if_stage.

Test Plan:
- Reset, imem_ready=1 constant, imem_rdata=addr+16'h1000:
  - imem_req=0 for one cycle, then addresses 0,1,2,…
  - instruction sequence 16'h1000,16'h1001,… with pc_id 0,1,2.
- Memory wait: imem_ready low for 3 cycles at addr 5 → imem_addr held at 5, 3 NOPs into ID, then word 16'h1005 with pc_id=5.
- Stall: instruction_fetch_en=0 for 2 cycles while word 7 completes:
  - instruction holds word 6; imem_req drops after capture.
  - On release, word 7 is emitted with no re-fetch of address 7.
- Branch taken at pc_id=20, offset −6'd10:
  - next instruction=NOP; next imem_addr=11.
  - Following instruction=16'h100B with pc_id=11.
- Branch during a pending wait at addr 9, target 30:
  - addr 9 is held until ready and its data is discarded.
  - Next request addr=30; no word from 9 reaches ID.
- Wrap-around and reset:
  - pc=16'hFFFF fetch → next imem_addr=16'h0000.
  - rst=0 mid-request → imem_req=0 and instruction=NOP immediately; refetch starts from 0.
